// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: drives the register file's single write port from two
// result streams. ALU results go straight to the registered write slot.
// Load results are queued in a small FIFO and drained when the ALU is idle,
// or forcibly when the FIFO is full. ld_busy tells decode which registers
// still have a queued load write pending.
//
// Optional feature macro: WB_BYPASS_EN. When defined, a load that arrives
// while the FIFO is empty and the ALU is idle skips the FIFO and lands in
// the write slot directly (latency 1).
module wb_port_arbiter #(
  parameter int LD_DEPTH = 4,
  parameter int DW       = 32,
  parameter int AW       = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [AW-1:0]               alu_rd,
  input  logic [DW-1:0]               alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [AW-1:0]               ld_rd,
  input  logic [DW-1:0]               ld_data,
  output logic                        rf_we,
  output logic [AW-1:0]               rf_addr,
  output logic [DW-1:0]               rf_wdata,
  output logic [(1<<AW)-1:0]          ld_busy,
  output logic [$clog2(LD_DEPTH):0]   ld_count
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(LD_DEPTH);

  // Load FIFO storage; pointers carry one extra bit so full and empty differ.
  logic [AW-1:0] fifo_rd   [LD_DEPTH];
  logic [DW-1:0] fifo_data [LD_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          bypass;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;

  assign ld_count  = wr_ptr - rd_ptr;
  assign full      = (ld_count == FULL_COUNT);
  assign empty     = (ld_count == '0);

  // A full FIFO takes priority over the ALU so loads can never starve;
  // otherwise the FIFO only drains in cycles the ALU leaves free.
  assign pop       = !empty && (full || !alu_valid);
  assign alu_ready = !full;
  assign ld_ready  = !full || pop;

`ifdef WB_BYPASS_EN
  assign bypass    = ld_valid && !alu_valid && empty;
`else
  assign bypass    = 1'b0;
`endif

  assign push      = ld_valid && ld_ready && !bypass;
  assign head_rd   = fifo_rd[rd_ptr[PW-1:0]];
  assign head_data = fifo_data[rd_ptr[PW-1:0]];

  // Capture accepted loads at the tail; contents need no reset since
  // occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[PW-1:0]]   <= ld_rd;
      fifo_data[wr_ptr[PW-1:0]] <= ld_data;
    end
  end

  // Advance the FIFO pointers; reset discards every queued load.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Load the registered write slot from whichever source wins this cycle;
  // writes to register 0 complete the handshake but never assert rf_we.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= (head_rd != '0);
      rf_addr  <= head_rd;
      rf_wdata <= head_data;
    end else if (alu_valid) begin
      rf_we    <= (alu_rd != '0);
      rf_addr  <= alu_rd;
      rf_wdata <= alu_data;
    end else if (bypass) begin
      rf_we    <= (ld_rd != '0);
      rf_addr  <= ld_rd;
      rf_wdata <= ld_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Mark every register targeted by a live FIFO entry so decode can stall.
  always_comb begin
    ld_busy = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (({1'b0, PW'(i) - rd_ptr[PW-1:0]} < ld_count) && (fifo_rd[i] != '0)) begin
        ld_busy[fifo_rd[i]] = 1'b1;
      end
    end
  end

endmodule
